// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq.
// The upstream stage drives the master side; alu_seq is the slave.
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] ain;
    logic [WIDTH-1:0] bin;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic [3:0]       status;

    modport master (
        output in_valid, ain, bin, op, out_ready,
        input  in_ready, out_valid, out, status
    );

    modport slave (
        input  in_valid, ain, bin, op, out_ready,
        output in_ready, out_valid, out, status
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake and {V,C,N,Z} status.
// ALU_SEQ_MUL_EN builds the iterative multiplier for op 111; otherwise op 111 acts as MOVA.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input logic       clk,
    input logic       reset_n,
    alu_seq_if.slave  alu
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;
`else
    typedef enum logic [1:0] {StIdle, StDone} state_e;
`endif

    state_e           r_state;
    state_e           w_state_next;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_accept;
    logic             w_is_mul;
    logic [WIDTH-1:0] r_out;
    logic [3:0]       r_status;

    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic [WIDTH:0]   w_wide;
    logic [CNT_W-1:0] w_shamt;

    always_comb begin
        w_res   = '0;
        w_c     = 1'b0;
        w_v     = 1'b0;
        w_wide  = '0;
        w_shamt = alu.bin[CNT_W-1:0];
        case (alu.op)
            3'b000: begin
                w_wide = {1'b0, alu.ain} + {1'b0, alu.bin};
                w_res  = w_wide[WIDTH-1:0];
                w_c    = w_wide[WIDTH];
                w_v    = (alu.ain[WIDTH-1] == alu.bin[WIDTH-1]) &&
                         (w_res[WIDTH-1] != alu.ain[WIDTH-1]);
            end
            3'b001: begin
                // Carry out of ain + ~bin + 1 is the inverted borrow
                w_wide = {1'b0, alu.ain} + {1'b0, ~alu.bin} + {{WIDTH{1'b0}}, 1'b1};
                w_res  = w_wide[WIDTH-1:0];
                w_c    = w_wide[WIDTH];
                w_v    = (alu.ain[WIDTH-1] != alu.bin[WIDTH-1]) &&
                         (w_res[WIDTH-1] != alu.ain[WIDTH-1]);
            end
            3'b010: w_res = alu.ain & alu.bin;
            3'b011: w_res = alu.ain;
            3'b100: w_res = alu.ain | alu.bin;
            3'b101: w_res = alu.ain ^ alu.bin;
            3'b110: begin
                if (int'(w_shamt) < WIDTH) begin
                    w_wide = {1'b0, alu.ain} << w_shamt;
                    w_res  = w_wide[WIDTH-1:0];
                    w_c    = w_wide[WIDTH];
                end
            end
            default: w_res = alu.ain;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] w_acc_next;
    logic               w_mul_last;

    assign w_is_mul   = (alu.op == 3'b111);
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mul_last = (r_cnt == CNT_W'(WIDTH - 1));
`else
    assign w_is_mul = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            StIdle: begin
                w_in_ready = 1'b1;
                if (alu.in_valid) begin
`ifdef ALU_SEQ_MUL_EN
                    w_state_next = w_is_mul ? StMul : StDone;
`else
                    w_state_next = StDone;
`endif
                end
            end
`ifdef ALU_SEQ_MUL_EN
            StMul: begin
                if (w_mul_last) begin
                    w_state_next = StDone;
                end
            end
`endif
            StDone: begin
                w_out_valid = 1'b1;
                w_in_ready  = alu.out_ready;
                if (alu.out_ready) begin
                    if (alu.in_valid) begin
`ifdef ALU_SEQ_MUL_EN
                        w_state_next = w_is_mul ? StMul : StDone;
`else
                        w_state_next = StDone;
`endif
                    end else begin
                        w_state_next = StIdle;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign w_accept = alu.in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_out    <= '0;
            r_status <= 4'b0001;
`ifdef ALU_SEQ_MUL_EN
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
`endif
        end else if (w_accept && !w_is_mul) begin
            r_out    <= w_res;
            r_status <= {w_v, w_c, w_res[WIDTH-1], (w_res == '0)};
`ifdef ALU_SEQ_MUL_EN
        end else if (w_accept) begin
            r_mcand  <= {{WIDTH{1'b0}}, alu.ain};
            r_mplier <= alu.bin;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == StMul) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            // Last iteration commits the accumulator including this cycle's partial product
            if (w_mul_last) begin
                r_out    <= w_acc_next[WIDTH-1:0];
                r_status <= {1'b0, |w_acc_next[2*WIDTH-1:WIDTH], w_acc_next[WIDTH-1],
                             (w_acc_next[WIDTH-1:0] == '0)};
            end
`endif
        end
    end

    assign alu.in_ready  = w_in_ready;
    assign alu.out_valid = w_out_valid;
    assign alu.out       = r_out;
    assign alu.status    = r_status;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus randomized traffic against a
// transaction-level model; MUL cases are built when ALU_SEQ_MUL_EN is defined.
module tb_alu_seq;
    localparam int W = 16;
    localparam longint MASK = (longint'(1) << W) - 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) alu ();

    alu_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .alu     (alu)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns {status, out} computed from the arithmetic definition of each op
    function automatic logic [W+3:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        longint ua, ub, sa, sb, r, sr, sh, res;
        bit c, v, n, z;
        ua = a;
        ub = b;
        sa = ua - (a[W-1] ? (longint'(1) << W) : 0);
        sb = ub - (b[W-1] ? (longint'(1) << W) : 0);
        c = 0;
        v = 0;
        r = 0;
        case (op)
            3'd0: begin r = ua + ub; c = (r > MASK); sr = sa + sb;
                        v = (sr > 32767) || (sr < -32768); end
            3'd1: begin r = ua - ub; c = (ua >= ub); sr = sa - sb;
                        v = (sr > 32767) || (sr < -32768); end
            3'd2: r = ua & ub;
            3'd3: r = ua;
            3'd4: r = ua | ub;
            3'd5: r = ua ^ ub;
            3'd6: begin
                sh = ub % 32;
                if (sh < W) begin r = ua << sh; c = ((r >> W) & 1) != 0; end
            end
            default: begin
`ifdef ALU_SEQ_MUL_EN
                r = ua * ub; c = (r >> W) != 0;
`else
                r = ua;
`endif
            end
        endcase
        res = r & MASK;
        z = (res == 0);
        n = ((res >> (W - 1)) & 1) != 0;
        return {v, c, n, z, res[W-1:0]};
    endfunction

    task automatic drive(input logic iv, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        alu.in_valid = iv;
        alu.op = op;
        alu.ain = a;
        alu.bin = b;
    endtask

    task automatic test_reset();
        drive(1'b0, 3'd0, '0, '0);
        alu.out_ready = 1'b1;
        reset_n = 1'b0;
        tick();
        tick();
        n_checks++; if (alu.out !== 16'h0)
            begin n_fail++; $display("FAIL reset_out got %h want 0000", alu.out); end
        n_checks++; if (alu.status !== 4'b0001)
            begin n_fail++; $display("FAIL reset_status got %b want 0001", alu.status); end
        n_checks++; if (alu.out_valid !== 1'b0)
            begin n_fail++; $display("FAIL reset_out_valid got %b want 0", alu.out_valid); end
        n_checks++; if (alu.in_ready !== 1'b1)
            begin n_fail++; $display("FAIL reset_in_ready got %b want 1", alu.in_ready); end
        reset_n = 1'b1;
    endtask

    task automatic test_add_overflow();
        drive(1'b1, 3'd0, 16'h7FFF, 16'h0001);
        tick();
        alu.in_valid = 1'b0;
        n_checks++; if (alu.out_valid !== 1'b1)
            begin n_fail++; $display("FAIL add_valid got %b want 1", alu.out_valid); end
        n_checks++; if (alu.out !== 16'h8000)
            begin n_fail++; $display("FAIL add_out got %h want 8000", alu.out); end
        n_checks++; if (alu.status !== 4'b1010)
            begin n_fail++; $display("FAIL add_status got %b want 1010", alu.status); end
        tick();
        n_checks++; if (alu.out_valid !== 1'b0)
            begin n_fail++; $display("FAIL add_idle got %b want 0", alu.out_valid); end
    endtask

    task automatic test_sub();
        logic [W-1:0] av[2] = '{16'h0005, 16'h0003};
        logic [W-1:0] bv[2] = '{16'h0005, 16'h0005};
        logic [W-1:0] eo[2] = '{16'h0000, 16'hFFFE};
        logic [3:0]   es[2] = '{4'b0101, 4'b0010};
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 3'd1, av[i], bv[i]);
            tick();
            alu.in_valid = 1'b0;
            n_checks++; if (alu.out !== eo[i] || alu.status !== es[i]) begin
                n_fail++;
                $display("FAIL sub_%0d got %h/%b want %h/%b", i, alu.out, alu.status,
                         eo[i], es[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]   ops[3] = '{3'd2, 3'd5, 3'd6};
        logic [W-1:0] av[3]  = '{16'hF0F0, 16'hFFFF, 16'h0001};
        logic [W-1:0] bv[3]  = '{16'h0FF0, 16'h00FF, 16'h0004};
        logic [W-1:0] eo[3]  = '{16'h00F0, 16'hFF00, 16'h0010};
        alu.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ops[i], av[i], bv[i]);
            #1;
            n_checks++; if (alu.in_ready !== 1'b1)
                begin n_fail++; $display("FAIL b2b_ready_%0d got %b want 1", i, alu.in_ready); end
            tick();
            n_checks++; if (alu.out_valid !== 1'b1 || alu.out !== eo[i]) begin
                n_fail++;
                $display("FAIL b2b_out_%0d got %b/%h want 1/%h", i, alu.out_valid, alu.out, eo[i]);
            end
        end
        alu.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_in_done();
        drive(1'b1, 3'd0, 16'h0001, 16'h0001);
        alu.out_ready = 1'b0;
        tick();
        alu.in_valid = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        alu.out_ready = 1'b1;
        n_checks++; if (alu.out_valid !== 1'b0 || alu.out !== 16'h0 || alu.status !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_done got %b/%h/%b want 0/0000/0001", alu.out_valid, alu.out,
                     alu.status);
        end
    endtask

`ifdef ALU_SEQ_MUL_EN
    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W+3:0] exp;
        exp = ref_alu(3'd7, a, b);
        alu.out_ready = 1'b1;
        drive(1'b1, 3'd7, a, b);
        tick();
        // Scrambled inputs during the multiply must not leak into the result
        for (int i = 0; i < W; i++) begin
            drive(i < W - 1, 3'd0, 16'h1234, 16'h4321);
            n_checks++; if (alu.in_ready !== 1'b0 || alu.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mul_busy_%0d got rdy=%b vld=%b want 0/0", i, alu.in_ready,
                         alu.out_valid);
            end
            tick();
        end
        n_checks++; if (alu.out_valid !== 1'b1 || {alu.status, alu.out} !== exp) begin
            n_fail++;
            $display("FAIL mul_result got %b/%b/%h want 1/%b/%h", alu.out_valid, alu.status,
                     alu.out, exp[W+3:W], exp[W-1:0]);
        end
        alu.out_ready = 1'b0;
        drive(1'b1, 3'd0, 16'h0001, 16'h0001);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (alu.in_ready !== 1'b0)
                begin n_fail++; $display("FAIL mul_stall_rdy got %b want 0", alu.in_ready); end
            tick();
            n_checks++; if (alu.out_valid !== 1'b1 || {alu.status, alu.out} !== exp) begin
                n_fail++;
                $display("FAIL mul_hold_%0d got %b/%h want %b/%h", i, alu.status, alu.out,
                         exp[W+3:W], exp[W-1:0]);
            end
        end
        alu.out_ready = 1'b1;
        alu.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_mul();
        run_mul(16'h0100, 16'h0101);
        run_mul(16'hABCD, 16'h0000);
        for (int k = 0; k < 3; k++) run_mul(W'($urandom), W'($urandom));
    endtask

    task automatic test_reset_mid_mul();
        drive(1'b1, 3'd7, 16'h00FF, 16'h00FF);
        tick();
        alu.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        n_checks++; if (alu.out_valid !== 1'b0 || alu.out !== 16'h0 || alu.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_reset got vld=%b out=%h rdy=%b want 0/0000/1", alu.out_valid,
                     alu.out, alu.in_ready);
        end
        drive(1'b1, 3'd0, 16'h0002, 16'h0003);
        tick();
        alu.in_valid = 1'b0;
        n_checks++; if (alu.out_valid !== 1'b1 || alu.out !== 16'h0005) begin
            n_fail++;
            $display("FAIL mul_reset_add got %b/%h want 1/0005", alu.out_valid, alu.out);
        end
        tick();
    endtask
`else
    task automatic test_op7_mova();
        drive(1'b1, 3'd7, 16'h8421, 16'h1111);
        tick();
        alu.in_valid = 1'b0;
        n_checks++; if (alu.out_valid !== 1'b1 || alu.out !== 16'h8421 ||
                        alu.status !== 4'b0010) begin
            n_fail++;
            $display("FAIL op7_mova got %b/%h/%b want 1/8421/0010", alu.out_valid, alu.out,
                     alu.status);
        end
        tick();
    endtask
`endif

    task automatic test_random();
        bit           exp_v = 1'b0;
        logic [W+3:0] exp = '0;
        logic         iv, ordy;
        logic [2:0]   op;
        logic [W-1:0] a, b;
        for (int i = 0; i < 300; i++) begin
            n_checks++; if (alu.out_valid !== exp_v) begin
                n_fail++;
                $display("FAIL rnd_valid_%0d got %b want %b", i, alu.out_valid, exp_v);
            end
            if (exp_v) begin
                n_checks++; if ({alu.status, alu.out} !== exp) begin
                    n_fail++;
                    $display("FAIL rnd_data_%0d got %b/%h want %b/%h", i, alu.status, alu.out,
                             exp[W+3:W], exp[W-1:0]);
                end
            end
`ifdef ALU_SEQ_MUL_EN
            op = 3'($urandom_range(0, 6));
`else
            op = 3'($urandom_range(0, 7));
`endif
            iv = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            a = W'($urandom);
            b = (op == 3'd6) ? W'($urandom_range(0, 40)) : W'($urandom);
            if ($urandom_range(0, 7) == 0) b = a;
            drive(iv, op, a, b);
            alu.out_ready = ordy;
            #1;
            n_checks++; if (alu.in_ready !== (!exp_v || ordy)) begin
                n_fail++;
                $display("FAIL rnd_ready_%0d got %b want %b", i, alu.in_ready, !exp_v || ordy);
            end
            if (iv && (!exp_v || ordy)) begin
                exp_v = 1'b1;
                exp = ref_alu(op, a, b);
            end else if (exp_v && ordy) begin
                exp_v = 1'b0;
            end
            tick();
        end
        alu.in_valid = 1'b0;
        alu.out_ready = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub();
        test_back_to_back();
        test_reset_in_done();
`ifdef ALU_SEQ_MUL_EN
        test_mul();
        test_reset_mid_mul();
`else
        test_op7_mova();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
